sseg_scan_driver: RTL

Parametrised multiplexed seven-segment scan driver for N digits split across B banks of K digits each (Boolean board: 8 digits, 2 banks of 4). Decodes per-digit hex nibbles internally and scans one digit per bank at a time. Provides the following:
- Brightness PWM.
- An anti-ghosting guard interval.
- Frame-synchronous, tear-free shadow update of displayed values.
Sits between game/debug logic (coordinate, score readout) and the board's anode/segment pins.

---
 rtl/sseg_pkg.sv | 20 ++
 rtl/sseg_hex_decode.sv | 11 +
 rtl/sseg_scan_driver.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared types, segment lookup table and timing helper for the seven-segment
// scan driver.
package sseg_pkg;

  // Segment pattern, bit order {g,f,e,d,c,b,a}, active-high.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
  };

  // Clock cycles spent on one digit before moving to the next.
  function automatic int dwell_cycles(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to seven-segment decoder (active-high segments).
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scan driver: one digit per bank is driven at a
// time, with a dark guard interval at the start of each dwell, PWM brightness
// and frame-synchronous (tear-free) loading of the displayed values.
// Optional build macro: SSEG_LZ_SUPPRESS_EN blanks leading zeros per bank.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int DIGITS_PER_BANK = 4,
  parameter int CLK_HZ          = 100_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter int GUARD           = 64,
  parameter int PWM_BITS        = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [4*NUM_DIGITS-1:0]                       digits,
  input  logic [NUM_DIGITS-1:0]                         blank,
  input  logic [NUM_DIGITS-1:0]                         dp,
  input  logic                                          upd,
  input  logic [PWM_BITS-1:0]                           brightness,
  output logic                                          upd_pending,
  output logic                                          frame_start,
  output logic [NUM_DIGITS/DIGITS_PER_BANK*DIGITS_PER_BANK-1:0] an,
  output logic [8*(NUM_DIGITS/DIGITS_PER_BANK)-1:0]     seg
);

  localparam int K     = DIGITS_PER_BANK;
  localparam int NB    = NUM_DIGITS / K;
  localparam int DWELL = dwell_cycles(CLK_HZ, SCAN_HZ);
  localparam int TW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW    = $clog2(K);

  localparam logic [TW-1:0] TICK_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] GUARD_T   = TW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(K - 1);

  logic [TW-1:0]       tick;
  logic [IW-1:0]       idx;
  logic [PWM_BITS-1:0] pwm;
  logic                tick_wrap, frame_bnd, lit, guard_done;

  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_blank, pend_dp, act_blank, act_dp, eff_blank;

  logic [NB*K-1:0] an_nxt;
  logic [8*NB-1:0] seg_nxt;

  assign tick_wrap  = (tick == TICK_LAST);
  assign frame_bnd  = tick_wrap && (idx == IDX_LAST);
  assign lit        = (brightness == '1) || (pwm < brightness);
  assign guard_done = (tick >= GUARD_T);

  // Dwell tick, shared digit index, free-running PWM phase, frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick        <= '0;
      idx         <= '0;
      pwm         <= '0;
      frame_start <= 1'b0;
    end else begin
      tick        <= tick_wrap ? '0 : tick + 1'b1;
      if (tick_wrap) idx <= idx + 1'b1;
      pwm         <= pwm + 1'b1;
      frame_start <= frame_bnd;
    end
  end

  // Shadow registers: updates are parked in pending and only reach the
  // active set on a frame boundary; an upd on the boundary itself bypasses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_digits <= '0;
      pend_blank  <= '0;
      pend_dp     <= '0;
      upd_pending <= 1'b0;
      act_digits  <= '0;
      act_blank   <= '1;
      act_dp      <= '0;
    end else if (frame_bnd) begin
      if (upd) begin
        act_digits <= digits;
        act_blank  <= blank;
        act_dp     <= dp;
      end else if (upd_pending) begin
        act_digits <= pend_digits;
        act_blank  <= pend_blank;
        act_dp     <= pend_dp;
      end
      upd_pending <= 1'b0;
    end else if (upd) begin
      pend_digits <= digits;
      pend_blank  <= blank;
      pend_dp     <= dp;
      upd_pending <= 1'b1;
    end
  end

`ifdef SSEG_LZ_SUPPRESS_EN
  logic zero_run;

  // Blank every digit sitting above the most significant nonzero digit of
  // its bank; the bank's lowest digit is never suppressed.
  always_comb begin
    eff_blank = act_blank;
    zero_run  = 1'b1;
    for (int b = 0; b < NB; b++) begin
      zero_run = 1'b1;
      for (int j = K - 1; j >= 1; j--) begin
        zero_run = zero_run && (act_digits[(b*K+j)*4 +: 4] == 4'h0);
        if (zero_run) eff_blank[b*K+j] = 1'b1;
      end
    end
  end
`else
  assign eff_blank = act_blank;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [K-1:0][3:0] bank_dig;
    logic [K-1:0]      bank_blank, bank_dp;
    logic [3:0]        cur_nib;
    logic              cur_blank, cur_dp;
    seg_t              dec;

    assign bank_dig   = act_digits[b*K*4 +: K*4];
    assign bank_blank = eff_blank[b*K +: K];
    assign bank_dp    = act_dp[b*K +: K];
    assign cur_nib    = bank_dig[idx];
    assign cur_blank  = bank_blank[idx];
    assign cur_dp     = bank_dp[idx];

    sseg_hex_decode u_dec (.nibble(cur_nib), .seg(dec));

    assign an_nxt[b*K +: K] = (guard_done && lit && !cur_blank) ?
                              ~(K'(1) << idx) : '1;
    assign seg_nxt[b*8 +: 8] = cur_blank ? 8'hFF : {~cur_dp, ~dec};
  end

  // Registered pin drivers; dark while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule
